// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared constants and types for the branch redirect controller:
// control-flow opcodes, sequencer states and the flush counter width.
package branch_ctrl_pkg;

    localparam logic [6:0] B_OPC  = 7'b1100011;
    localparam logic [6:0] J_OPC  = 7'b1101111;
    localparam int         FCNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic logic is_branch_or_jump(input logic [6:0] opc);
        return (opc == B_OPC) || (opc == J_OPC);
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// EX-stage branch resolution in, front-end redirect/flush and statistics out.
// The EX side presents its inputs every cycle; there is no valid/ready handshake.
interface branch_redirect_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    import branch_ctrl_pkg::*;

    logic             ex_valid;
    logic [6:0]       opcode;
    logic             br_taken;
    logic [XLEN-1:0]  br_target;
    logic             stall_in;

    logic             pc_sel;
    logic [XLEN-1:0]  pc_target;
    logic             flush_if;
    logic             flush_id;
    logic             busy;
    logic [CNT_W-1:0] ctrl_cnt;
    logic [CNT_W-1:0] taken_cnt;
    logic             err;
    state_t           state;

    modport master (
        output ex_valid, opcode, br_taken, br_target, stall_in,
        input  pc_sel, pc_target, flush_if, flush_id, busy,
               ctrl_cnt, taken_cnt, err, state
    );

    modport slave (
        input  ex_valid, opcode, br_taken, br_target, stall_in,
        output pc_sel, pc_target, flush_if, flush_id, busy,
               ctrl_cnt, taken_cnt, err, state
    );

endinterface

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Front-end redirect sequencer: captures a taken branch/jump from EX, waits out
// back-end stalls, then pulses pc_sel once and holds the IF/ID flush.
module branch_redirect_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic reset,
    branch_redirect_ctrl_if.slave bus
);

    localparam logic [FCNT_W-1:0] FLUSH_INIT = FCNT_W'(FLUSH_CYCLES - 1);

    state_t            r_state;
    logic [FCNT_W-1:0] r_cnt;
    logic [XLEN-1:0]   r_target;
    logic              r_pc_sel;
    logic              r_flush;
    logic              r_err;

    logic w_is_bj;
    logic w_is_ctrl;
    logic w_take;
    logic w_idle;

    assign w_is_bj   = is_branch_or_jump(bus.opcode);
    assign w_is_ctrl = bus.ex_valid && w_is_bj;
    assign w_take    = w_is_ctrl && bus.br_taken;
    assign w_idle    = (r_state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_target <= '0;
            r_pc_sel <= 1'b0;
            r_flush  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_pc_sel <= 1'b0;
            if (bus.ex_valid && bus.br_taken && !w_is_bj) begin
                r_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_target <= bus.br_target;
                        if (bus.stall_in) begin
                            r_state <= PEND;
                        end else begin
                            r_pc_sel <= 1'b1;
                            r_flush  <= 1'b1;
                            r_cnt    <= FLUSH_INIT;
                            r_state  <= FLUSH;
                        end
                    end
                end
                // EX is frozen with the same instruction, so its inputs are ignored here
                PEND: begin
                    if (!bus.stall_in) begin
                        r_pc_sel <= 1'b1;
                        r_flush  <= 1'b1;
                        r_cnt    <= FLUSH_INIT;
                        r_state  <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (!bus.stall_in) begin
                        if (r_cnt == '0) begin
                            r_flush <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Statistics only count in IDLE so a frozen EX instruction is seen once
    sat_counter #(.W(CNT_W)) u_ctrl_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_is_ctrl && w_idle),
        .q     (bus.ctrl_cnt)
    );

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_take && w_idle),
        .q     (bus.taken_cnt)
    );

    assign bus.pc_sel    = r_pc_sel;
    assign bus.pc_target = r_target;
    assign bus.flush_if  = r_flush;
    assign bus.flush_id  = r_flush;
    assign bus.busy      = !w_idle;
    assign bus.err       = r_err;
    assign bus.state     = r_state;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: two instances (FLUSH_CYCLES=2/CNT_W=16 and
// FLUSH_CYCLES=1/CNT_W=2) driven with identical stimulus and checked every cycle.
module tb_branch_redirect_ctrl;
    import branch_ctrl_pkg::*;

    localparam logic [6:0] R_OPC = 7'b0110011;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    branch_redirect_ctrl_if #(.XLEN(32), .CNT_W(16)) if0 ();
    branch_redirect_ctrl_if #(.XLEN(32), .CNT_W(2))  if1 ();

    branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(16)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
    );

    branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(1), .CNT_W(2)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a pending flag plus the number of flush cycles still to show
    int          m_fc[2]   = '{2, 1};
    int          m_max[2]  = '{65535, 3};
    bit          m_pend[2];
    int          m_fl[2];
    logic [31:0] m_tgt[2];
    bit          m_psel[2];
    int          m_ctrl[2];
    int          m_taken[2];
    bit          m_err[2];

    task automatic model_step(input int k, input logic v, input logic [6:0] op,
                              input logic t, input logic [31:0] tg, input logic st,
                              input logic rst);
        bit idle;
        bit bj;
        if (rst) begin
            m_pend[k] = 0; m_fl[k] = 0; m_tgt[k] = '0; m_psel[k] = 0;
            m_ctrl[k] = 0; m_taken[k] = 0; m_err[k] = 0;
            return;
        end
        idle = !m_pend[k] && (m_fl[k] == 0);
        bj   = (op == B_OPC) || (op == J_OPC);
        if (v && t && !bj) m_err[k] = 1;
        m_psel[k] = 0;
        if (idle && v && bj && m_ctrl[k] < m_max[k]) m_ctrl[k]++;
        if (m_fl[k] > 0) begin
            if (!st) m_fl[k]--;
        end else if (m_pend[k]) begin
            if (!st) begin
                m_pend[k] = 0; m_fl[k] = m_fc[k]; m_psel[k] = 1;
            end
        end else if (v && bj && t) begin
            m_tgt[k] = tg;
            if (m_taken[k] < m_max[k]) m_taken[k]++;
            if (st) m_pend[k] = 1;
            else begin
                m_fl[k] = m_fc[k]; m_psel[k] = 1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("d0.pc_sel",    32'(if0.pc_sel),    32'(m_psel[0]));
        chk("d0.pc_target", if0.pc_target,      m_tgt[0]);
        chk("d0.flush_if",  32'(if0.flush_if),  32'(m_fl[0] > 0));
        chk("d0.flush_id",  32'(if0.flush_id),  32'(m_fl[0] > 0));
        chk("d0.busy",      32'(if0.busy),      32'(m_pend[0] || m_fl[0] > 0));
        chk("d0.ctrl_cnt",  32'(if0.ctrl_cnt),  32'(m_ctrl[0]));
        chk("d0.taken_cnt", 32'(if0.taken_cnt), 32'(m_taken[0]));
        chk("d0.err",       32'(if0.err),       32'(m_err[0]));
        chk("d1.pc_sel",    32'(if1.pc_sel),    32'(m_psel[1]));
        chk("d1.pc_target", if1.pc_target,      m_tgt[1]);
        chk("d1.flush_if",  32'(if1.flush_if),  32'(m_fl[1] > 0));
        chk("d1.flush_id",  32'(if1.flush_id),  32'(m_fl[1] > 0));
        chk("d1.busy",      32'(if1.busy),      32'(m_pend[1] || m_fl[1] > 0));
        chk("d1.ctrl_cnt",  32'(if1.ctrl_cnt),  32'(m_ctrl[1]));
        chk("d1.taken_cnt", 32'(if1.taken_cnt), 32'(m_taken[1]));
        chk("d1.err",       32'(if1.err),       32'(m_err[1]));
    endtask

    // Drive one cycle of inputs, clock it, advance the model, compare after the edge
    task automatic step(input logic v, input logic [6:0] op, input logic t,
                        input logic [31:0] tg, input logic st, input logic rst);
        reset         = rst;
        if0.ex_valid  = v;  if1.ex_valid  = v;
        if0.opcode    = op; if1.opcode    = op;
        if0.br_taken  = t;  if1.br_taken  = t;
        if0.br_target = tg; if1.br_target = tg;
        if0.stall_in  = st; if1.stall_in  = st;
        @(posedge clk);
        model_step(0, v, op, t, tg, st, rst);
        model_step(1, v, op, t, tg, st, rst);
        #1;
        compare_all();
    endtask

    task automatic idle_step(input logic st);
        step(1'b0, 7'h00, 1'b0, 32'h0, st, 1'b0);
    endtask

    typedef struct {
        logic        v;
        logic [6:0]  op;
        logic        t;
        logic [31:0] tg;
        logic        st;
        logic        e_psel;
        logic        e_flush;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [6:0] op, logic t, logic [31:0] tg,
                                logic st, logic ep, logic ef, logic eb);
        vec_t r;
        r.v = v; r.op = op; r.t = t; r.tg = tg; r.st = st;
        r.e_psel = ep; r.e_flush = ef; r.e_busy = eb;
        return r;
    endfunction

    initial begin
        int fl_len;
        int pulses;
        n_tests = 0;
        n_fail  = 0;

        // Expected d0 outputs in the cycle after each row is applied
        tbl.push_back(mk(1, B_OPC, 1, 32'h100, 0, 1, 1, 1));
        tbl.push_back(mk(0, 7'h00, 0, 32'h0,   0, 0, 1, 1));
        tbl.push_back(mk(0, 7'h00, 0, 32'h0,   0, 0, 0, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(1, J_OPC, 1, 32'h200, 1, 0, 0, 1));
        tbl.push_back(mk(1, J_OPC, 1, 32'h200, 0, 1, 1, 1));
        tbl.push_back(mk(0, 7'h00, 0, 32'h0,   0, 0, 1, 1));
        tbl.push_back(mk(0, 7'h00, 0, 32'h0,   0, 0, 0, 0));
        tbl.push_back(mk(1, B_OPC, 0, 32'h300, 0, 0, 0, 0));
        tbl.push_back(mk(0, B_OPC, 1, 32'h400, 0, 0, 0, 0));

        reset = 1'b1;
        step(1'b0, 7'h00, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("reset.state", 32'(if0.state), 32'(IDLE));
        for (int i = 0; i < 4; i++) idle_step(1'b0);

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].op, tbl[i].t, tbl[i].tg, tbl[i].st, 1'b0);
            chk($sformatf("tbl%0d.pc_sel", i), 32'(if0.pc_sel),   32'(tbl[i].e_psel));
            chk($sformatf("tbl%0d.flush", i),  32'(if0.flush_if), 32'(tbl[i].e_flush));
            chk($sformatf("tbl%0d.busy", i),   32'(if0.busy),     32'(tbl[i].e_busy));
            if (tbl[i].e_psel) chk($sformatf("tbl%0d.target", i), if0.pc_target, tbl[i].tg);
        end
        chk("tbl.ctrl_cnt",  32'(if0.ctrl_cnt),  32'd3);
        chk("tbl.taken_cnt", 32'(if0.taken_cnt), 32'd2);

        // Stall arriving in the second flush cycle stretches the flush by 3
        fl_len = 0;
        pulses = 0;
        step(1'b1, B_OPC, 1'b1, 32'h500, 1'b0, 1'b0);
        fl_len += int'(if0.flush_if); pulses += int'(if0.pc_sel);
        idle_step(1'b0);
        fl_len += int'(if0.flush_if); pulses += int'(if0.pc_sel);
        for (int i = 0; i < 3; i++) begin
            idle_step(1'b1);
            fl_len += int'(if0.flush_if); pulses += int'(if0.pc_sel);
        end
        for (int i = 0; i < 3; i++) begin
            idle_step(1'b0);
            fl_len += int'(if0.flush_if); pulses += int'(if0.pc_sel);
        end
        chk("sdf.flush_len", 32'(fl_len), 32'd5);
        chk("sdf.pulses",    32'(pulses), 32'd1);

        // Taken on a non-control opcode: sticky error, no redirect
        step(1'b1, R_OPC, 1'b1, 32'h600, 1'b0, 1'b0);
        chk("err.pc_sel", 32'(if0.pc_sel), 32'd0);
        for (int i = 0; i < 3; i++) idle_step(1'b0);
        chk("err.sticky", 32'(if0.err), 32'd1);

        // Saturation on the 2-bit counter instance
        step(1'b0, 7'h00, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, J_OPC, 1'b1, 32'h700 + 32'(i), 1'b0, 1'b0);
            idle_step(1'b0);
        end
        chk("sat.taken_cnt", 32'(if1.taken_cnt), 32'd3);
        chk("sat.ctrl_cnt",  32'(if1.ctrl_cnt),  32'd3);

        // Reset while a redirect is pending drops it silently
        step(1'b0, 7'h00, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, B_OPC, 1'b1, 32'h800, 1'b1, 1'b0);
        idle_step(1'b1);
        chk("rpend.busy", 32'(if0.busy), 32'd1);
        step(1'b0, 7'h00, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("rpend.state", 32'(if0.state), 32'(IDLE));
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            idle_step(1'b0);
            pulses += int'(if0.pc_sel) + int'(if1.pc_sel);
        end
        chk("rpend.pulses", 32'(pulses), 32'd0);
        chk("rpend.target", if0.pc_target, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] op;
            case ($urandom_range(0, 3))
                0:       op = B_OPC;
                1:       op = J_OPC;
                2:       op = R_OPC;
                default: op = 7'($urandom_range(0, 127));
            endcase
            step(1'($urandom_range(0, 9) < 7), op, 1'($urandom_range(0, 1)),
                 $urandom, 1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
